// File: rtl/clk_speed_pkg.sv
// rtl/clk_speed_pkg.sv - shared types, gen-speed codes and defaults for the clock speed sequencer
package clk_speed_pkg;

  typedef enum logic [2:0] {
    ST_INIT_SETTLE,
    ST_READY,
    ST_WAIT_IDLE,
    ST_DRAIN,
    ST_SWITCH,
    ST_SETTLE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] GEN_00 = 2'b00;
  localparam logic [1:0] GEN_01 = 2'b01;
  localparam logic [1:0] GEN_10 = 2'b10;
  localparam logic [1:0] GEN_11 = 2'b11;

  localparam int         DEF_DRAIN_CYCLES  = 16;
  localparam int         DEF_SETTLE_CYCLES = 64;
  localparam int         DEF_IDLE_TIMEOUT  = 255;
  localparam int         DEF_CNT_W         = 8;
  localparam logic [1:0] DEF_RESET_GEN     = GEN_00;

  // Output levels owned by each state; registered from the next state so
  // they line up with the state register.
  typedef struct packed {
    logic clk_en;
    logic busy;
    logic req_ready;
    logic done;
    logic err;
    logic div_rst_n;
  } outs_t;

  function automatic outs_t decode_outs(input state_t s);
    outs_t o;
    o.clk_en    = (s == ST_READY) || (s == ST_WAIT_IDLE) ||
                  (s == ST_DONE)  || (s == ST_ERR);
    o.busy      = (s != ST_READY);
    o.req_ready = (s == ST_READY);
    o.done      = (s == ST_DONE);
    o.err       = (s == ST_ERR);
    o.div_rst_n = (s != ST_SWITCH);
    return o;
  endfunction

endpackage

// File: rtl/clk_seq_timer.sv
// rtl/clk_seq_timer.sv - saturating interval counter with synchronous clear and terminal compare
module clk_seq_timer
  import clk_speed_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             local_clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] count;

  // Count up from zero after each clear; hold at all-ones instead of wrapping.
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != {CNT_W{1'b1}}) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == term);

endmodule

// File: rtl/clk_speed_ctrl.sv
// rtl/clk_speed_ctrl.sv - gen-speed change sequencer with clock gating, drain and settle intervals
module clk_speed_ctrl
  import clk_speed_pkg::*;
#(
  parameter int         DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
  parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int         IDLE_TIMEOUT  = DEF_IDLE_TIMEOUT,
  parameter int         CNT_W         = DEF_CNT_W,
  parameter logic [1:0] RESET_GEN     = DEF_RESET_GEN
) (
  input  logic       local_clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_gen,
  output logic       req_ready,
  input  logic       link_idle,
  output logic [1:0] gen_speed,
  output logic       div_rst_n,
  output logic       clk_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       target;
  logic [CNT_W-1:0] term;
  logic             hit;
  logic             clr;
  outs_t            outs_nxt;

  // Transition rules; link_idle wins over the idle timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT_SETTLE: if (hit) state_nxt = ST_READY;
      ST_READY: begin
        if (req_valid) state_nxt = (req_gen == gen_speed) ? ST_DONE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (link_idle)  state_nxt = ST_DRAIN;
        else if (hit)   state_nxt = ST_ERR;
      end
      ST_DRAIN:       if (hit) state_nxt = ST_SWITCH;
      ST_SWITCH:      state_nxt = ST_SETTLE;
      ST_SETTLE:      if (hit) state_nxt = ST_DONE;
      ST_DONE:        state_nxt = ST_READY;
      ST_ERR:         state_nxt = ST_READY;
      default:        state_nxt = ST_INIT_SETTLE;
    endcase
  end

  // Terminal count for the interval owned by the current state.
  always_comb begin
    case (state)
      ST_INIT_SETTLE: term = CNT_W'(SETTLE_CYCLES - 1);
      ST_SETTLE:      term = CNT_W'(SETTLE_CYCLES - 1);
      ST_DRAIN:       term = CNT_W'(DRAIN_CYCLES - 1);
      ST_WAIT_IDLE:   term = CNT_W'(IDLE_TIMEOUT);
      default:        term = '0;
    endcase
  end

  assign clr      = (state_nxt != state);
  assign outs_nxt = decode_outs(state_nxt);

  clk_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .local_clk (local_clk),
    .rst       (rst),
    .clr       (clr),
    .term      (term),
    .hit       (hit)
  );

  // State register, registered outputs, latched target and gen_speed update on SWITCH entry.
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_INIT_SETTLE;
      gen_speed <= RESET_GEN;
      target    <= RESET_GEN;
      clk_en    <= 1'b0;
      busy      <= 1'b1;
      req_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      div_rst_n <= 1'b1;
    end else begin
      state     <= state_nxt;
      clk_en    <= outs_nxt.clk_en;
      busy      <= outs_nxt.busy;
      req_ready <= outs_nxt.req_ready;
      done      <= outs_nxt.done;
      err       <= outs_nxt.err;
      div_rst_n <= outs_nxt.div_rst_n;
      if (state == ST_READY && req_valid) begin
        target <= req_gen;
      end
      if (state_nxt == ST_SWITCH && state != ST_SWITCH) begin
        gen_speed <= target;
      end
    end
  end

endmodule

// File: tb/tb_clk_speed_ctrl.sv
// tb/tb_clk_speed_ctrl.sv - scoreboard bench for the gen-speed change sequencer
module tb_clk_speed_ctrl;

  localparam int D  = 16;
  localparam int S  = 64;
  localparam int IT = 255;

  logic       local_clk = 1'b0;
  logic       rst       = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_gen   = 2'b00;
  logic       link_idle = 1'b0;
  logic       req_ready;
  logic [1:0] gen_speed;
  logic       div_rst_n;
  logic       clk_en;
  logic       busy;
  logic       done;
  logic       err;

  typedef struct {
    int kind;
    int cyc;
    int gen;
    int gated;
  } ev_t;

  typedef struct {
    int cyc;
    int gen;
  } sw_t;

  ev_t  ev_q[$];
  sw_t  sw_q[$];
  int   cyc           = 0;
  int   vectors       = 0;
  int   miscompares   = 0;
  int   model_gen     = 0;
  int   exp_ready_cyc = 0;
  int   ready_gen_exp = 0;
  int   gated         = 0;
  logic prev_ready    = 1'b0;
  ev_t  mon_e;
  sw_t  mon_s;

  clk_speed_ctrl #(
    .DRAIN_CYCLES  (D),
    .SETTLE_CYCLES (S),
    .IDLE_TIMEOUT  (IT),
    .CNT_W         (8),
    .RESET_GEN     (2'b00)
  ) dut (
    .local_clk (local_clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_gen   (req_gen),
    .req_ready (req_ready),
    .link_idle (link_idle),
    .gen_speed (gen_speed),
    .div_rst_n (div_rst_n),
    .clk_en    (clk_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 local_clk = ~local_clk;

  always @(posedge local_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected at cycle %0d", name, cyc);
  endtask

  // Monitor: pops expected switch/completion records and checks ready timing.
  always @(negedge local_clk) begin
    if (rst) begin
      if (req_ready && !prev_ready) begin
        check("ready_cycle", cyc, exp_ready_cyc);
        check("ready_gen", gen_speed, ready_gen_exp);
        check("ready_clk_en", clk_en, 1);
        gated = 0;
      end
      if (!clk_en) gated++;
      if (!div_rst_n) begin
        if (sw_q.size() == 0) begin
          flag("switch_unexpected");
        end else begin
          mon_s = sw_q.pop_front();
          check("switch_cycle", cyc, mon_s.cyc);
          check("switch_gen", gen_speed, mon_s.gen);
        end
      end
      if (done || err) begin
        if (ev_q.size() == 0) begin
          flag("event_unexpected");
        end else begin
          mon_e = ev_q.pop_front();
          check("event_kind", err ? 1 : 0, mon_e.kind);
          check("event_cycle", cyc, mon_e.cyc);
          check("event_gen", gen_speed, mon_e.gen);
          check("event_gated_cycles", gated, mon_e.gated);
          check("event_clk_en", clk_en, 1);
          exp_ready_cyc = mon_e.cyc + 1;
          ready_gen_exp = mon_e.gen;
        end
      end
      prev_ready = req_ready;
    end else begin
      prev_ready = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gen_speed"}, gen_speed, 0);
    check({tag, "_clk_en"}, clk_en, 0);
    check({tag, "_div_rst_n"}, div_rst_n, 1);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Issue one request; w = WAIT_IDLE cycles with link_idle low before it rises.
  task automatic do_req(input int r, input int w, input bit disturb, input bit abort);
    int  t;
    int  ev_cyc;
    bit  hs;
    bit  change;
    @(posedge local_clk); #1;
    req_valid = 1'b1;
    req_gen   = 2'(r);
    link_idle = (w == 0);
    hs = 1'b0;
    t  = 0;
    for (int b = 0; b < 2000 && !hs; b++) begin
      @(negedge local_clk);
      if (req_ready) begin
        hs = 1'b1;
        t  = cyc;
      end
    end
    if (!hs) begin
      flag("handshake_timeout");
      req_valid = 1'b0;
      return;
    end
    change = (r != model_gen);
    if (!change) begin
      ev_cyc = t + 1;
      ev_q.push_back('{0, ev_cyc, r, 0});
    end else if (w <= IT) begin
      ev_cyc = t + 3 + w + D + S;
      sw_q.push_back('{t + 2 + w + D, r});
      ev_q.push_back('{0, ev_cyc, r, D + 1 + S});
      model_gen = r;
    end else begin
      ev_cyc = t + 2 + IT;
      ev_q.push_back('{1, ev_cyc, model_gen, 0});
    end
    @(posedge local_clk); #1;
    req_valid = 1'b0;
    if (change && w <= IT) begin
      repeat (w) @(posedge local_clk);
      #1;
      link_idle = 1'b1;
      if (disturb) begin
        repeat (2) @(posedge local_clk);
        #1;
        link_idle = 1'b0;
        req_valid = 1'b1;
        req_gen   = 2'($urandom_range(0, 3));
        repeat (3) @(posedge local_clk);
        #1;
        req_valid = 1'b0;
      end
      if (abort) begin
        while (cyc < t + w + D + 23) begin
          @(posedge local_clk); #1;
        end
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midseq_reset");
        ev_q.delete();
        sw_q.delete();
        model_gen     = 0;
        ready_gen_exp = 0;
        repeat (3) @(posedge local_clk);
        #1;
        rst = 1'b1;
        exp_ready_cyc = cyc + S;
        return;
      end
    end
    while (cyc < ev_cyc) begin
      @(posedge local_clk); #1;
    end
  endtask

  initial begin
    int r;
    int w;
    rst = 1'b0;
    repeat (3) @(posedge local_clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    exp_ready_cyc = cyc + S;
    ready_gen_exp = 0;

    do_req(2, 0, 1'b0, 1'b0);
    do_req(2, 3, 1'b0, 1'b0);
    do_req(1, 255, 1'b0, 1'b0);
    do_req(3, 256, 1'b0, 1'b0);
    do_req(0, 300, 1'b0, 1'b0);
    do_req(0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 3);
      w = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
      do_req(r, w, 1'($urandom_range(0, 1)), 1'b0);
    end
    do_req((model_gen == 3) ? 1 : 3, 2, 1'b0, 1'b1);
    do_req(0, 0, 1'b0, 1'b0);
    do_req(3, 5, 1'b0, 1'b0);
    do_req(3, 0, 1'b0, 1'b0);

    for (int b = 0; b < 1000 && (ev_q.size() + sw_q.size()) != 0; b++) begin
      @(posedge local_clk);
    end
    repeat (4) @(posedge local_clk);
    check("queues_drained", ev_q.size() + sw_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
